// File: rtl/msrv32_wb_pipe_unit.sv
// rtl/msrv32_wb_pipe_unit.sv - registered writeback source select with load stall, x0 suppression and flush
// Optional forwarding hit outputs are built when MSRV32_WB_FWD_EN is defined.
module msrv32_wb_pipe_unit #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 flush_in,
   input  logic                 in_valid_in,
   output logic                 in_ready_out,
   input  logic [2:0]           wb_mux_sel_in,
   input  logic                 rf_wr_en_in,
   input  logic [RF_ADDR_W-1:0] rd_addr_in,
   input  logic [XLEN-1:0]      alu_result_in,
   input  logic [XLEN-1:0]      lu_output_in,
   input  logic [XLEN-1:0]      imm_in,
   input  logic [XLEN-1:0]      iadder_out_in,
   input  logic [XLEN-1:0]      csr_data_in,
   input  logic [XLEN-1:0]      pc_plus_4_in,
   input  logic [XLEN-1:0]      rs2_in,
   input  logic                 lu_valid_in,
   input  logic                 alu_source_in,
   output logic [XLEN-1:0]      alu_2nd_src_mux_out,
   output logic                 rf_wr_en_out,
   output logic [RF_ADDR_W-1:0] rf_rd_addr_out,
   output logic [XLEN-1:0]      rf_wr_data_out,
   output logic                 sel_err_out
`ifdef MSRV32_WB_FWD_EN
   ,
   input  logic [RF_ADDR_W-1:0] rs1_addr_in,
   input  logic [RF_ADDR_W-1:0] rs2_addr_in,
   output logic                 fwd_rs1_hit_out,
   output logic                 fwd_rs2_hit_out
`endif
);

   localparam logic [2:0] SEL_ALU    = 3'b000;
   localparam logic [2:0] SEL_LU     = 3'b001;
   localparam logic [2:0] SEL_IMM    = 3'b010;
   localparam logic [2:0] SEL_IADDER = 3'b011;
   localparam logic [2:0] SEL_CSR    = 3'b100;
   localparam logic [2:0] SEL_PC4    = 3'b101;

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   state_t                 r_state;
   logic                   r_wr_en;
   logic [RF_ADDR_W-1:0]   r_rd_addr;
   logic [XLEN-1:0]        r_wr_data;
   logic                   r_sel_err;
   logic [RF_ADDR_W-1:0]   r_pend_rd;
   logic                   r_pend_en;

   logic                   w_accept;
   logic                   w_is_lu;
   logic                   w_is_rsvd;
   logic                   w_commit;
   logic [XLEN-1:0]        w_src;

   assign in_ready_out = (r_state == IDLE) && !flush_in;
   assign w_accept     = in_valid_in && in_ready_out;
   assign w_is_lu      = (wb_mux_sel_in == SEL_LU);
   assign w_is_rsvd    = wb_mux_sel_in[2] && wb_mux_sel_in[1];
   assign w_commit     = rf_wr_en_in && (rd_addr_in != '0);

   assign alu_2nd_src_mux_out = alu_source_in ? rs2_in : imm_in;

   // Writeback source select; reserved codes fall back to the ALU result.
   always_comb begin
      w_src = alu_result_in;
      case (wb_mux_sel_in)
         SEL_ALU:    w_src = alu_result_in;
         SEL_LU:     w_src = lu_output_in;
         SEL_IMM:    w_src = imm_in;
         SEL_IADDER: w_src = iadder_out_in;
         SEL_CSR:    w_src = csr_data_in;
         SEL_PC4:    w_src = pc_plus_4_in;
         default:    w_src = alu_result_in;
      endcase
   end

   // Writeback FSM: address/data only move on a real write so they hold otherwise.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state   <= IDLE;
         r_wr_en   <= 1'b0;
         r_rd_addr <= '0;
         r_wr_data <= '0;
         r_sel_err <= 1'b0;
         r_pend_rd <= '0;
         r_pend_en <= 1'b0;
      end else if (flush_in) begin
         r_state   <= IDLE;
         r_wr_en   <= 1'b0;
         r_sel_err <= 1'b0;
      end else begin
         r_wr_en   <= 1'b0;
         r_sel_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_is_lu && !lu_valid_in) begin
                     r_pend_rd <= rd_addr_in;
                     r_pend_en <= rf_wr_en_in;
                     r_state   <= LOAD_WAIT;
                  end else begin
                     r_sel_err <= w_is_rsvd;
                     if (w_commit) begin
                        r_wr_en   <= 1'b1;
                        r_rd_addr <= rd_addr_in;
                        r_wr_data <= w_src;
                     end
                  end
               end
            end
            LOAD_WAIT: begin
               if (lu_valid_in) begin
                  r_state <= IDLE;
                  if (r_pend_en && (r_pend_rd != '0)) begin
                     r_wr_en   <= 1'b1;
                     r_rd_addr <= r_pend_rd;
                     r_wr_data <= lu_output_in;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rf_wr_en_out   = r_wr_en;
   assign rf_rd_addr_out = r_rd_addr;
   assign rf_wr_data_out = r_wr_data;
   assign sel_err_out    = r_sel_err;

`ifdef MSRV32_WB_FWD_EN
   assign fwd_rs1_hit_out = r_wr_en && (r_rd_addr == rs1_addr_in) && (rs1_addr_in != '0);
   assign fwd_rs2_hit_out = r_wr_en && (r_rd_addr == rs2_addr_in) && (rs2_addr_in != '0);
`endif

endmodule

// File: tb/tb_msrv32_wb_pipe_unit.sv
// tb/tb_msrv32_wb_pipe_unit.sv - self-checking bench for msrv32_wb_pipe_unit
module tb_msrv32_wb_pipe_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  sel;
   logic        wr_en_in;
   logic [4:0]  rd;
   logic [31:0] alu, lu, imm, iadd, csr, pc4, rs2;
   logic        lu_valid;
   logic        alu_src;
   logic [31:0] mux2;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        sel_err;
`ifdef MSRV32_WB_FWD_EN
   logic [4:0]  rs1_addr, rs2_addr;
   logic        hit1, hit2;
`endif

   int total = 0;
   int bad   = 0;

   // model state
   bit          m_wait;
   logic [4:0]  m_prd;
   bit          m_pen;
   bit          m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_err;

   always #5 clk = ~clk;

   msrv32_wb_pipe_unit #(.XLEN(32), .RF_ADDR_W(5)) dut (
      .clk_in              (clk),
      .rst_n_in            (rst_n),
      .flush_in            (flush),
      .in_valid_in         (in_valid),
      .in_ready_out        (in_ready),
      .wb_mux_sel_in       (sel),
      .rf_wr_en_in         (wr_en_in),
      .rd_addr_in          (rd),
      .alu_result_in       (alu),
      .lu_output_in        (lu),
      .imm_in              (imm),
      .iadder_out_in       (iadd),
      .csr_data_in         (csr),
      .pc_plus_4_in        (pc4),
      .rs2_in              (rs2),
      .lu_valid_in         (lu_valid),
      .alu_source_in       (alu_src),
      .alu_2nd_src_mux_out (mux2),
      .rf_wr_en_out        (wr_en),
      .rf_rd_addr_out      (wr_addr),
      .rf_wr_data_out      (wr_data),
      .sel_err_out         (sel_err)
`ifdef MSRV32_WB_FWD_EN
      ,
      .rs1_addr_in         (rs1_addr),
      .rs2_addr_in         (rs2_addr),
      .fwd_rs1_hit_out     (hit1),
      .fwd_rs2_hit_out     (hit2)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick(input logic [2:0] s);
      logic [31:0] src [8];
      src[0] = alu; src[1] = lu;  src[2] = imm; src[3] = iadd;
      src[4] = csr; src[5] = pc4; src[6] = alu; src[7] = alu;
      return src[s];
   endfunction

   // Reference: next-cycle writeback outcome from current inputs, taken just before an edge.
   task automatic model_clock();
      m_en  = 0;
      m_err = 0;
      if (flush) begin
         m_wait = 0;
      end else if (m_wait) begin
         if (lu_valid) begin
            m_wait = 0;
            if (m_pen && m_prd != 0) begin
               m_en = 1; m_addr = m_prd; m_data = lu;
            end
         end
      end else if (in_valid) begin
         if (sel == 3'd1 && !lu_valid) begin
            m_wait = 1; m_prd = rd; m_pen = wr_en_in;
         end else begin
            m_err = (sel >= 3'd6);
            if (wr_en_in && rd != 0) begin
               m_en = 1; m_addr = rd; m_data = pick(sel);
            end
         end
      end
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; sel = 0; wr_en_in = 0; rd = 0;
      alu = 0; lu = 0; imm = 0; iadd = 0; csr = 0; pc4 = 0; rs2 = 0;
      lu_valid = 0; alu_src = 0;
`ifdef MSRV32_WB_FWD_EN
      rs1_addr = 0; rs2_addr = 0;
`endif
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      #3;
      total++; if (wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
      total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", wr_addr); end
      total++; if (wr_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", wr_data); end
      total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%0b exp=0", sel_err); end
      tick(); tick();
      rst_n = 1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_alu();
      in_valid = 1; sel = 3'd0; rd = 5'd5; wr_en_in = 1; alu = 32'h1234_5678;
      tick();
      in_valid = 0;
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL alu_wr_en got=%0b exp=1", wr_en); end
      total++; if (wr_addr !== 5'd5) begin bad++; $display("FAIL alu_addr got=%0d exp=5", wr_addr); end
      total++; if (wr_data !== 32'h1234_5678) begin bad++; $display("FAIL alu_data got=%h exp=12345678", wr_data); end
      tick();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL alu_strobe_end got=%0b exp=0", wr_en); end
      total++; if (wr_addr !== 5'd5) begin bad++; $display("FAIL alu_addr_hold got=%0d exp=5", wr_addr); end
   endtask

   task automatic test_x0();
      in_valid = 1; sel = 3'd5; rd = 5'd0; wr_en_in = 1; pc4 = 32'h104;
      tick();
      in_valid = 0;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL x0_wr_en got=%0b exp=0", wr_en); end
      total++; if (wr_data !== 32'h1234_5678) begin bad++; $display("FAIL x0_data_hold got=%h exp=12345678", wr_data); end
   endtask

   task automatic test_load_wait();
      in_valid = 1; sel = 3'd1; rd = 5'd7; wr_en_in = 1; lu_valid = 0; lu = 32'h0;
      tick();
      // new instruction presented while waiting must be ignored
      sel = 3'd0; rd = 5'd9; alu = 32'h9999;
      for (int i = 0; i < 3; i++) begin
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lw_ready[%0d] got=%0b exp=0", i, in_ready); end
         total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL lw_wr_en[%0d] got=%0b exp=0", i, wr_en); end
         tick();
      end
      lu_valid = 1; lu = 32'hDEAD_BEEF;
      tick();
      in_valid = 0; lu_valid = 0;
      #1;
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL lw_wr_en got=%0b exp=1", wr_en); end
      total++; if (wr_addr !== 5'd7) begin bad++; $display("FAIL lw_addr got=%0d exp=7", wr_addr); end
      total++; if (wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", wr_data); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lw_ready_back got=%0b exp=1", in_ready); end
      tick();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL lw_no_extra got=%0b exp=0", wr_en); end
   endtask

   task automatic test_flush_load();
      in_valid = 1; sel = 3'd1; rd = 5'd8; wr_en_in = 1; lu_valid = 0;
      tick();
      in_valid = 0;
      tick();
      lu_valid = 1; lu = 32'h55; flush = 1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%0b exp=0", in_ready); end
      tick();
      flush = 0; lu_valid = 0;
      #1;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL fl_wr_en got=%0b exp=0", wr_en); end
      total++; if (wr_addr !== 5'd7) begin bad++; $display("FAIL fl_addr_hold got=%0d exp=7", wr_addr); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_idle got=%0b exp=1", in_ready); end
      in_valid = 1; sel = 3'd0; rd = 5'd2; alu = 32'h2222;
      tick();
      in_valid = 0;
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd2) begin bad++; $display("FAIL fl_after en=%0b addr=%0d exp en=1 addr=2", wr_en, wr_addr); end
      // flush drops the instruction presented in the same cycle
      in_valid = 1; flush = 1; rd = 5'd3; alu = 32'h3333;
      tick();
      in_valid = 0; flush = 0;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL fl_drop got=%0b exp=0", wr_en); end
   endtask

   task automatic test_reserved();
      in_valid = 1; sel = 3'd7; rd = 5'd4; wr_en_in = 1; alu = 32'hA5;
      tick();
      in_valid = 0;
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL rsv_wr_en got=%0b exp=1", wr_en); end
      total++; if (wr_data !== 32'hA5) begin bad++; $display("FAIL rsv_data got=%h exp=a5", wr_data); end
      total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL rsv_err got=%0b exp=1", sel_err); end
      tick();
      total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL rsv_err_pulse got=%0b exp=0", sel_err); end
   endtask

   task automatic test_mux();
      alu_src = 0; imm = 32'h10; rs2 = 32'h20;
      #1;
      total++; if (mux2 !== 32'h10) begin bad++; $display("FAIL mux_imm got=%h exp=10", mux2); end
      alu_src = 1;
      #1;
      total++; if (mux2 !== 32'h20) begin bad++; $display("FAIL mux_rs2 got=%h exp=20", mux2); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h111; vals[1] = 32'h222; vals[2] = 32'h333;
      in_valid = 1; sel = 3'd2; wr_en_in = 1;
      for (int i = 0; i < 3; i++) begin
         rd = 5'(10 + i); imm = vals[i];
         tick();
         total++; if (wr_en !== 1'b1 || wr_addr !== 5'(10 + i) || wr_data !== vals[i]) begin
            bad++; $display("FAIL b2b[%0d] en=%0b addr=%0d data=%h exp en=1 addr=%0d data=%h",
                            i, wr_en, wr_addr, wr_data, 10 + i, vals[i]);
         end
      end
      in_valid = 0;
      tick();
   endtask

   task automatic test_reset_mid_wait();
      in_valid = 1; sel = 3'd1; rd = 5'd6; wr_en_in = 1; lu_valid = 0;
      tick();
      in_valid = 0;
      rst_n = 0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmw_ready got=%0b exp=1", in_ready); end
      lu_valid = 1; lu = 32'h77;
      tick();
      rst_n = 1;
      tick();
      lu_valid = 0;
      total++; if (wr_en !== 1'b0 || wr_data !== 32'd0) begin bad++; $display("FAIL rmw_no_write en=%0b data=%h exp en=0 data=0", wr_en, wr_data); end
   endtask

`ifdef MSRV32_WB_FWD_EN
   task automatic test_fwd();
      in_valid = 1; sel = 3'd0; rd = 5'd3; wr_en_in = 1; alu = 32'h3;
      rs1_addr = 5'd3; rs2_addr = 5'd4;
      tick();
      in_valid = 0;
      total++; if (hit1 !== 1'b1 || hit2 !== 1'b0) begin bad++; $display("FAIL fwd got=%0b%0b exp=10", hit1, hit2); end
      tick();
   endtask
`endif

   task automatic test_random();
      idle_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      m_wait = 0; m_prd = 0; m_pen = 0; m_en = 0; m_addr = 0; m_data = 0; m_err = 0;
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         sel      = 3'($urandom_range(0, 7));
         wr_en_in = ($urandom_range(0, 4) != 0);
         rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         lu_valid = ($urandom_range(0, 2) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         alu = $urandom; lu = $urandom; imm = $urandom; iadd = $urandom;
         csr = $urandom; pc4 = $urandom; rs2 = $urandom;
         #1;
         total++; if (in_ready !== (!m_wait && !flush)) begin bad++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", i, in_ready, !m_wait && !flush); end
         model_clock();
         tick();
         total++; if (wr_en !== m_en || sel_err !== m_err || wr_addr !== m_addr || wr_data !== m_data) begin
            bad++; $display("FAIL rnd_out[%0d] en=%0b err=%0b addr=%0d data=%h exp en=%0b err=%0b addr=%0d data=%h",
                            i, wr_en, sel_err, wr_addr, wr_data, m_en, m_err, m_addr, m_data);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_x0();
      test_load_wait();
      test_flush_load();
      test_reserved();
      test_mux();
      test_back_to_back();
      test_reset_mid_wait();
`ifdef MSRV32_WB_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
